alu_reservation_station: RTL

ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

---
 rtl/alu_reservation_station_pkg.sv | 47 ++++
 rtl/alu_reservation_station_rs_priority_select.sv | 26 ++
 rtl/alu_reservation_station.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: widths, ALU control word and
// the per-entry record held in each station slot.
package alu_reservation_station_pkg;

  localparam int PHYSICAL_REG_NUM_WIDTH = 6;
  localparam int REG_VAL_WIDTH          = 32;
  localparam int INST_ADDR_WIDTH        = 32;
  localparam int ROB_SIZE_WIDTH         = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src;   // 1: second operand is the immediate
  } control_t;

  typedef enum logic [1:0] {
    RS_FREE    = 2'd0,
    RS_WAITING = 2'd1,
    RS_READY   = 2'd2
  } rs_state_t;

  typedef struct packed {
    rs_state_t                         state;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] src1_tag;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] src2_tag;
    logic                              src1_rdy;
    logic                              src2_rdy;
    logic [REG_VAL_WIDTH-1:0]          src1_val;
    logic [REG_VAL_WIDTH-1:0]          src2_val;
    logic [PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg;
    control_t                          control;
    logic [REG_VAL_WIDTH-1:0]          immediate;
    logic [INST_ADDR_WIDTH-1:0]        pc;
    logic [ROB_SIZE_WIDTH-1:0]         rob_tag;
  } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_rs_priority_select.sv
// Lowest-index picker: returns one-hot grant, its binary index and an any flag.
module rs_priority_select #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    // Walk downward so the lowest set bit is the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands arrive via
// dispatch or CDB snoop, then issues one op at a time to a single ALU.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_DEPTH       = 4,
  parameter int RS_DEPTH_WIDTH = $clog2(RS_DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              disp_valid,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] disp_src1_tag,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] disp_src2_tag,
  input  logic                              disp_src1_rdy,
  input  logic                              disp_src2_rdy,
  input  logic [REG_VAL_WIDTH-1:0]          disp_src1_val,
  input  logic [REG_VAL_WIDTH-1:0]          disp_src2_val,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] disp_dst_reg_addr,
  input  control_t                          disp_control,
  input  logic [REG_VAL_WIDTH-1:0]          disp_immediate,
  input  logic [INST_ADDR_WIDTH-1:0]        disp_pc,
  input  logic [ROB_SIZE_WIDTH-1:0]         disp_rob_tag,
  output logic                              disp_ready,
  input  logic                              cdb_valid,
  input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] cdb_addr,
  input  logic [REG_VAL_WIDTH-1:0]          cdb_val,
  input  logic                              flush,
  output logic                              rs_valid,
  output logic [REG_VAL_WIDTH-1:0]          src_reg1_val,
  output logic [REG_VAL_WIDTH-1:0]          src_reg2_val,
  output logic [PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_addr,
  output control_t                          control,
  output logic [REG_VAL_WIDTH-1:0]          immediate,
  output logic [INST_ADDR_WIDTH-1:0]        pc_in,
  output logic [ROB_SIZE_WIDTH-1:0]         new_inst_tag_in,
  input  logic                              alu_ready
);

  rs_entry_t ent     [RS_DEPTH];
  rs_entry_t ent_nxt [RS_DEPTH];
  rs_entry_t iss_q;
  rs_entry_t new_ent;

  logic [RS_DEPTH-1:0]       free_vec, ready_vec;
  logic [RS_DEPTH-1:0]       alloc_oh, issue_oh;
  logic [RS_DEPTH_WIDTH-1:0] alloc_idx, issue_idx;
  logic                      any_free, any_ready;
  logic                      do_disp, do_issue;
  logic                      unused_sel;

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      free_vec[i]  = (ent[i].state == RS_FREE);
      ready_vec[i] = (ent[i].state == RS_READY);
    end
  end

  rs_priority_select #(.N(RS_DEPTH), .IDX_W(RS_DEPTH_WIDTH)) u_alloc_sel (
    .req    (free_vec),
    .onehot (alloc_oh),
    .idx    (alloc_idx),
    .any    (any_free)
  );

  rs_priority_select #(.N(RS_DEPTH), .IDX_W(RS_DEPTH_WIDTH)) u_issue_sel (
    .req    (ready_vec),
    .onehot (issue_oh),
    .idx    (issue_idx),
    .any    (any_ready)
  );

  assign unused_sel = ^alloc_oh;

  assign disp_ready = any_free;
  assign do_disp    = disp_valid && any_free && !flush;
  // rs_valid in the term keeps alu_ready out of a same-cycle loop and spaces issues.
  assign do_issue   = alu_ready && !rs_valid && !flush && any_ready;

  // Incoming entry with same-cycle CDB bypass applied to pending operands.
  always_comb begin
    new_ent           = '0;
    new_ent.src1_tag  = disp_src1_tag;
    new_ent.src2_tag  = disp_src2_tag;
    new_ent.src1_rdy  = disp_src1_rdy;
    new_ent.src2_rdy  = disp_src2_rdy;
    new_ent.src1_val  = disp_src1_val;
    new_ent.src2_val  = disp_src2_val;
    new_ent.dst_reg   = disp_dst_reg_addr;
    new_ent.control   = disp_control;
    new_ent.immediate = disp_immediate;
    new_ent.pc        = disp_pc;
    new_ent.rob_tag   = disp_rob_tag;
    if (cdb_valid && !disp_src1_rdy && (cdb_addr == disp_src1_tag)) begin
      new_ent.src1_rdy = 1'b1;
      new_ent.src1_val = cdb_val;
    end
    if (cdb_valid && !disp_src2_rdy && (cdb_addr == disp_src2_tag)) begin
      new_ent.src2_rdy = 1'b1;
      new_ent.src2_val = cdb_val;
    end
    new_ent.state = (new_ent.src1_rdy && new_ent.src2_rdy) ? RS_READY : RS_WAITING;
  end

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_nxt[i] = ent[i];
      if (ent[i].state == RS_WAITING && cdb_valid) begin
        if (!ent[i].src1_rdy && ent[i].src1_tag == cdb_addr) begin
          ent_nxt[i].src1_rdy = 1'b1;
          ent_nxt[i].src1_val = cdb_val;
        end
        if (!ent[i].src2_rdy && ent[i].src2_tag == cdb_addr) begin
          ent_nxt[i].src2_rdy = 1'b1;
          ent_nxt[i].src2_val = cdb_val;
        end
        if (ent_nxt[i].src1_rdy && ent_nxt[i].src2_rdy)
          ent_nxt[i].state = RS_READY;
      end
      if (do_issue && issue_oh[i])
        ent_nxt[i].state = RS_FREE;
      if (do_disp && alloc_idx == RS_DEPTH_WIDTH'(i))
        ent_nxt[i] = new_ent;
      if (flush)
        ent_nxt[i].state = RS_FREE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RS_DEPTH; i++) ent[i] <= '0;
      iss_q    <= '0;
      rs_valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) ent[i] <= ent_nxt[i];
      rs_valid <= do_issue;
      if (do_issue) iss_q <= ent[issue_idx];
    end
  end

  assign src_reg1_val    = iss_q.src1_val;
  assign src_reg2_val    = iss_q.src2_val;
  assign dst_reg_addr    = iss_q.dst_reg;
  assign control         = iss_q.control;
  assign immediate       = iss_q.immediate;
  assign pc_in           = iss_q.pc;
  assign new_inst_tag_in = iss_q.rob_tag;

endmodule
